// File: rtl/pr_region_freeze_ctrl_pkg.sv
// Shared types and defaults for the per-region PR freeze controller.
package pr_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STOP_WAIT  = 2'd1,
        FROZEN     = 2'd2,
        START_WAIT = 2'd3
    } pr_state_t;

    localparam int ILLEGAL_FREEZE   = 0;
    localparam int ILLEGAL_UNFREEZE = 1;

    localparam int DEF_RESET_MIN_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES   = 1024;
    localparam int DEF_CNT_W            = 11;

endpackage

// File: rtl/pr_region_freeze_ctrl_if.sv
// Conduit + region-logic signal bundle for one PR region freeze controller.
interface pr_region_freeze_ctrl_if;
    import pr_ctrl_pkg::*;

    // Conduit side: request levels in, status/flags out.
    logic       freeze_req;
    logic       unfreeze_req;
    logic       reset_req;
    logic       freeze_status;
    logic       unfreeze_status;
    logic [1:0] illegal_req;

    // Region-logic side. Handshake: the controller holds stop_req (or start_req)
    // high for the whole wait state; the region logic answers with a level
    // ack, which is only looked at while the matching req is high. The
    // req drops the cycle after the ack is sampled; ack outside its wait
    // state has no effect.
    logic       stop_req;
    logic       stop_ack;
    logic       start_req;
    logic       start_ack;

    // Region control.
    logic       freeze;
    logic       region_reset;
    logic       timeout;

    // Current controller state, for observation only.
    pr_state_t  dbg_state;

    modport master (
        output freeze_req, unfreeze_req, reset_req, stop_ack, start_ack,
        input  freeze_status, unfreeze_status, illegal_req, stop_req,
               start_req, freeze, region_reset, timeout, dbg_state
    );

    modport slave (
        input  freeze_req, unfreeze_req, reset_req, stop_ack, start_ack,
        output freeze_status, unfreeze_status, illegal_req, stop_req,
               start_req, freeze, region_reset, timeout, dbg_state
    );

endinterface

// File: rtl/pr_region_freeze_ctrl_edge.sv
// Registered rising-edge detector for a request level from the conduit.
module pr_req_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    output logic rise_o
);

    logic req_q;

    // Level history; cleared on reset so a level already high afterwards counts as a rise.
    always_ff @(posedge clk) begin
        if (reset) req_q <= 1'b0;
        else       req_q <= req_i;
    end

    assign rise_o = req_i & ~req_q;

endmodule

// File: rtl/pr_region_freeze_ctrl.sv
// Per-region PR freeze controller: stop/freeze/start handshake with the
// region logic, freeze bridge and region reset control, sticky error flags.
// Optional watchdog on the region handshake: define PR_FREEZE_TIMEOUT_EN.
module pr_region_freeze_ctrl
    import pr_ctrl_pkg::*;
#(
    parameter int RESET_MIN_CYCLES = DEF_RESET_MIN_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    pr_region_freeze_ctrl_if.slave bus
);

    localparam int LIMIT_MAX = (RESET_MIN_CYCLES > TIMEOUT_CYCLES) ? RESET_MIN_CYCLES : TIMEOUT_CYCLES;

    if ((RESET_MIN_CYCLES < 1) || (CNT_W < 1) || (CNT_W > 30) || ((1 << CNT_W) <= LIMIT_MAX)) begin : g_bad_params
        $error("pr_region_freeze_ctrl: CNT_W too narrow or RESET_MIN_CYCLES < 1");
    end

    logic frz_rise;
    logic unf_rise;
    logic rst_rise;

    pr_req_edge_det u_frz_det (.clk(clk), .reset(reset), .req_i(bus.freeze_req),   .rise_o(frz_rise));
    pr_req_edge_det u_unf_det (.clk(clk), .reset(reset), .req_i(bus.unfreeze_req), .rise_o(unf_rise));
    pr_req_edge_det u_rst_det (.clk(clk), .reset(reset), .req_i(bus.reset_req),    .rise_o(rst_rise));

    pr_state_t        state_q, state_d;
    logic [1:0]       illegal_q, illegal_d;
    logic             pend_q, pend_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rst_start;
    logic             rr_busy;
`ifdef PR_FREEZE_TIMEOUT_EN
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             to_q, to_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            illegal_q <= 2'b00;
            pend_q    <= 1'b0;
            rr_q      <= 1'b0;
            rcnt_q    <= '0;
`ifdef PR_FREEZE_TIMEOUT_EN
            wd_q      <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            rcnt_q    <= rcnt_d;
`ifdef PR_FREEZE_TIMEOUT_EN
            wd_q      <= wd_d;
            to_q      <= to_d;
`endif
        end
    end

    // Next state: request decode, region reset pulse, handshake completion.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        pend_d    = pend_q;
        rr_d      = rr_q;
        rcnt_d    = rcnt_q;
`ifdef PR_FREEZE_TIMEOUT_EN
        wd_d      = wd_q;
        to_d      = to_q;
`endif
        // A reset pulse starting this cycle blocks an unfreeze just like an active one.
        rst_start = (state_q == FROZEN) && !rr_q && rst_rise;
        rr_busy   = rr_q || rst_start;

        // Region reset: counter holds cycles already spent high, saturating at the minimum.
        if (rst_start) begin
            rr_d   = 1'b1;
            rcnt_d = CNT_W'(1);
        end else if (rr_q) begin
            if (!bus.reset_req && (rcnt_q >= CNT_W'(RESET_MIN_CYCLES))) begin
                rr_d   = 1'b0;
                rcnt_d = '0;
            end else if (rcnt_q < CNT_W'(RESET_MIN_CYCLES)) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end

        // Deferred unfreeze goes ahead once the reset pulse has ended.
        if ((state_q == FROZEN) && pend_q && !rr_busy) begin
            state_d   = START_WAIT;
            pend_d    = 1'b0;
            illegal_d = 2'b00;
        end

        if (frz_rise && unf_rise) begin
            illegal_d = 2'b11;
        end else if (frz_rise) begin
            if (state_q == RUN) begin
                state_d   = STOP_WAIT;
                illegal_d = 2'b00;
            end else begin
                illegal_d[ILLEGAL_FREEZE] = 1'b1;
            end
        end else if (unf_rise) begin
            if (state_q != FROZEN) begin
                illegal_d[ILLEGAL_UNFREEZE] = 1'b1;
            end else if (rr_busy) begin
                pend_d = 1'b1;
            end else begin
                state_d   = START_WAIT;
                pend_d    = 1'b0;
                illegal_d = 2'b00;
            end
        end

        case (state_q)
            STOP_WAIT:  if (bus.stop_ack)  state_d = FROZEN;
            START_WAIT: if (bus.start_ack) state_d = RUN;
            default: ;
        endcase

`ifdef PR_FREEZE_TIMEOUT_EN
        // Watchdog: forces the handshake through when the region logic never answers.
        if ((state_q == STOP_WAIT) || (state_q == START_WAIT)) begin
            if (state_d != state_q) begin
                wd_d = '0;
            end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                wd_d    = '0;
                to_d    = 1'b1;
                state_d = (state_q == STOP_WAIT) ? FROZEN : RUN;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    // Outputs decoded from registered state and flags only.
    always_comb begin
        bus.stop_req        = 1'b0;
        bus.start_req       = 1'b0;
        bus.freeze          = 1'b0;
        bus.freeze_status   = 1'b0;
        bus.unfreeze_status = 1'b0;
        unique case (state_q)
            RUN:        bus.unfreeze_status = 1'b1;
            STOP_WAIT:  bus.stop_req        = 1'b1;
            FROZEN: begin
                bus.freeze        = 1'b1;
                bus.freeze_status = 1'b1;
            end
            START_WAIT: bus.start_req       = 1'b1;
        endcase
        bus.illegal_req  = illegal_q;
        bus.region_reset = rr_q;
`ifdef PR_FREEZE_TIMEOUT_EN
        bus.timeout      = to_q;
`else
        bus.timeout      = 1'b0;
`endif
        bus.dbg_state    = state_q;
    end

endmodule

// File: tb/tb_pr_region_freeze_ctrl.sv
// Bench for pr_region_freeze_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pr_region_freeze_ctrl;

    localparam int RMIN = 16;
`ifdef PR_FREEZE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1024;
`endif
    localparam int P_RUN = 0;
    localparam int P_SW  = 1;
    localparam int P_FZ  = 2;
    localparam int P_STW = 3;
    localparam logic [8:0] RESET_VEC = 9'h010;

    logic clk = 1'b0;
    logic reset;

    pr_region_freeze_ctrl_if bus();

    pr_region_freeze_ctrl #(
        .RESET_MIN_CYCLES(RMIN),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit f, input bit u, input bit r, input bit sa, input bit ta);
        bus.freeze_req   = f;
        bus.unfreeze_req = u;
        bus.reset_req    = r;
        bus.stop_ack     = sa;
        bus.start_ack    = ta;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // {stop_req, start_req, freeze, freeze_status, unfreeze_status, illegal_req, region_reset, timeout}
    function automatic logic [8:0] dut_vec();
        return {bus.stop_req, bus.start_req, bus.freeze, bus.freeze_status, bus.unfreeze_status,
                bus.illegal_req, bus.region_reset, bus.timeout};
    endfunction

    // {stop_req, start_req, freeze, freeze_status, unfreeze_status} expected per phase.
    function automatic logic [4:0] phase_outs(input int p);
        case (p)
            P_RUN:   return 5'b00001;
            P_SW:    return 5'b10000;
            P_FZ:    return 5'b00110;
            default: return 5'b01000;
        endcase
    endfunction

    // Behavioural model: where the region is heading (tgt) and whether a region handshake is open (wt).
    bit         m_tgt, m_wt, m_pend, m_rr_on, m_to;
    logic [1:0] m_ill;
    int         m_left, m_wait;
    bit         pf, pu, pr;

    function automatic void model_reset();
        m_tgt = 0; m_wt = 0; m_pend = 0; m_rr_on = 0; m_to = 0;
        m_ill = 2'b00; m_left = 0; m_wait = 0;
        pf = 0; pu = 0; pr = 0;
    endfunction

    function automatic void model_step(input bit f, input bit u, input bit r, input bit sa, input bit ta);
        bit fr, ur, rrise, frozen_now, rst_start, busy, n_tgt, n_wt;
        logic [1:0] n_ill;
        fr = f && !pf;
        ur = u && !pu;
        rrise = r && !pr;
        pf = f; pu = u; pr = r;
        frozen_now = m_tgt && !m_wt;
        rst_start = frozen_now && !m_rr_on && rrise;
        busy = m_rr_on || rst_start;
        n_tgt = m_tgt; n_wt = m_wt; n_ill = m_ill;
        if (frozen_now && m_pend && !busy) begin
            n_tgt = 0; n_wt = 1; m_pend = 0; n_ill = 2'b00;
        end
        if (fr && ur) begin
            n_ill = 2'b11;
        end else if (fr) begin
            if (!m_tgt && !m_wt) begin n_tgt = 1; n_wt = 1; n_ill = 2'b00; end
            else n_ill[0] = 1'b1;
        end else if (ur) begin
            if (!frozen_now) n_ill[1] = 1'b1;
            else if (busy) m_pend = 1;
            else begin n_tgt = 0; n_wt = 1; m_pend = 0; n_ill = 2'b00; end
        end
        if (m_wt) begin
            if ((m_tgt && sa) || (!m_tgt && ta)) begin
                n_wt = 0; m_wait = 0;
            end else begin
`ifdef PR_FREEZE_TIMEOUT_EN
                m_wait++;
                if (m_wait == TMO) begin n_wt = 0; m_wait = 0; m_to = 1; end
`endif
            end
        end
        if (rst_start) begin
            m_rr_on = 1; m_left = RMIN - 1;
        end else if (m_rr_on) begin
            if (m_left == 0 && !r) m_rr_on = 0;
            else if (m_left > 0) m_left--;
        end
        m_tgt = n_tgt; m_wt = n_wt; m_ill = n_ill;
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_tgt && m_wt, !m_tgt && m_wt, m_tgt && !m_wt, m_tgt && !m_wt, !m_tgt && !m_wt,
                m_ill, m_rr_on, m_to};
    endfunction

    typedef struct {
        bit         f, u, r, sa, ta;
        int         ph;
        logic [1:0] ill;
        logic       rr;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int n;
        int bad;
        logic [8:0] v;

        tbl[0]  = '{0, 1, 0, 0, 0, P_RUN, 2'b10, 1'b0};
        tbl[1]  = '{0, 0, 0, 0, 0, P_RUN, 2'b10, 1'b0};
        tbl[2]  = '{1, 0, 0, 0, 0, P_SW,  2'b00, 1'b0};
        tbl[3]  = '{1, 0, 0, 0, 0, P_SW,  2'b00, 1'b0};
        tbl[4]  = '{0, 0, 0, 1, 0, P_FZ,  2'b00, 1'b0};
        tbl[5]  = '{1, 0, 0, 0, 0, P_FZ,  2'b01, 1'b0};
        tbl[6]  = '{0, 0, 0, 0, 1, P_FZ,  2'b01, 1'b0};
        tbl[7]  = '{0, 1, 0, 0, 0, P_STW, 2'b00, 1'b0};
        tbl[8]  = '{0, 0, 0, 1, 0, P_STW, 2'b00, 1'b0};
        tbl[9]  = '{0, 0, 0, 0, 1, P_RUN, 2'b00, 1'b0};
        tbl[10] = '{1, 1, 0, 0, 0, P_RUN, 2'b11, 1'b0};
        tbl[11] = '{0, 0, 1, 0, 0, P_RUN, 2'b11, 1'b0};
        tbl[12] = '{0, 0, 0, 0, 0, P_RUN, 2'b11, 1'b0};
        tbl[13] = '{1, 0, 0, 0, 0, P_SW,  2'b00, 1'b0};
        tbl[14] = '{1, 0, 0, 1, 0, P_FZ,  2'b00, 1'b0};
        tbl[15] = '{0, 0, 1, 0, 0, P_FZ,  2'b00, 1'b1};
        tbl[16] = '{0, 0, 0, 0, 0, P_FZ,  2'b00, 1'b1};

        // Reset values.
        do_reset();
        chk("reset_vec", dut_vec(), RESET_VEC);
        chk("reset_state", bus.dbg_state, 0);

        // Vector table.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].f, tbl[i].u, tbl[i].r, tbl[i].sa, tbl[i].ta);
            tick();
            v = dut_vec();
            chk($sformatf("tbl%0d_phase", i), v[8:4], phase_outs(tbl[i].ph));
            chk($sformatf("tbl%0d_illegal", i), v[3:2], tbl[i].ill);
            chk($sformatf("tbl%0d_region_reset", i), v[1], tbl[i].rr);
        end

        // Normal cycle: stop_ack five cycles after the freeze rise, start_ack after three.
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.stop_req) n++;
            if (k == 4) bus.stop_ack = 1'b1;
            tick();
        end
        chk("norm_stop_cycles", n, 5);
        chk("norm_frozen_outs", dut_vec(), 9'h060);
        drive(0, 1, 0, 0, 0);
        tick();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.start_req && !bus.freeze) n++;
            if (k == 2) bus.start_ack = 1'b1;
            tick();
        end
        chk("norm_start_cycles", n, 3);
        chk("norm_run_outs", dut_vec(), RESET_VEC);

        // Region reset: reset_req for two cycles, unfreeze rise on the fourth pulse cycle.
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        bus.stop_ack = 1'b0;
        chk("rr_frozen", bus.freeze_status, 1'b1);
        bus.reset_req = 1'b1;
        tick();
        chk("rr_start", bus.region_reset, 1'b1);
        n = 1;
        bad = 0;
        while (bus.region_reset && n < 40) begin
            if (!bus.freeze_status) bad++;
            bus.reset_req    = (n < 2);
            bus.unfreeze_req = (n >= 3);
            tick();
            if (bus.region_reset) n++;
        end
        chk("rr_pulse_cycles", n, RMIN);
        chk("rr_stayed_frozen", bad, 0);
        chk("rr_fall_still_frozen", dut_vec(), 9'h060);
        tick();
        chk("rr_deferred_unfreeze", dut_vec(), 9'h080);
        bus.start_ack = 1'b1;
        tick();
        chk("rr_back_to_run", dut_vec(), RESET_VEC);

        // Reset in the middle of a stop handshake, with illegal flag set and an ack arriving.
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0);
        tick();
        chk("mid_stop_illegal", dut_vec(), 9'h108);
        drive(0, 0, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset_vec", dut_vec(), RESET_VEC);
        tick();
        chk("mid_ack_ignored", dut_vec(), RESET_VEC);

`ifdef PR_FREEZE_TIMEOUT_EN
        // Watchdog: region logic never acks.
        do_reset();
        drive(1, 0, 0, 0, 0);
        tick();
        n = 0;
        while (bus.stop_req && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_stop_cycles", n, TMO);
        chk("tmo_frozen_flag", dut_vec(), 9'h061);
        drive(0, 1, 0, 0, 0);
        tick();
        n = 0;
        while (bus.start_req && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_start_cycles", n, TMO);
        chk("tmo_run_flag", dut_vec(), 9'h011);
        do_reset();
        chk("tmo_cleared", bus.timeout, 1'b0);
`endif

        // Randomized run against the model.
        do_reset();
        model_reset();
        begin
            bit f, u, r, sa, ta, rst;
            f = 0; u = 0; r = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) f = !f;
                if ($urandom_range(0, 5) == 0) u = !u;
                if ($urandom_range(0, 9) == 0) r = !r;
                sa  = ($urandom_range(0, 3) == 0);
                ta  = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 299) == 0);
                drive(f, u, r, sa, ta);
                reset = rst;
                if (rst) model_reset();
                else model_step(f, u, r, sa, ta);
                tick();
                chk($sformatf("rand%0d", i), dut_vec(), model_vec());
            end
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
